stream_demux_1_4: RTL

//   Routes one valid/ready input stream to one of four output streams, selected per beat by sel.

---
 rtl/stream_demux_pkg.sv | 18 +
 rtl/stream_slot.sv | 40 ++++
 rtl/stream_demux_1_4.sv | 42 ++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
package stream_demux_pkg;

    localparam int unsigned N_OUT = 4;
    localparam int unsigned SEL_W = $clog2(N_OUT);
    localparam int unsigned CNT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;

    // One-hot decode of a destination index.
    function automatic logic [N_OUT-1:0] sel_onehot(input sel_t s);
        logic [N_OUT-1:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry registered output slot: valid flag, payload register and delivered-beat counter.
module stream_slot
    import stream_demux_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] cnt
);

    logic drain;

    assign drain = out_valid & out_ready;

    // A load wins over a drain so a slot refilled on its drain edge stays valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            cnt       <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= data_in;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (drain) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stream_demux_1_4.sv
// Routes one valid/ready stream to one of four registered output slots chosen per beat by in_sel.
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  sel_t                   in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*W-1:0]     out_data,
    output logic [N_OUT*CNT_W-1:0] beat_cnt
);

    logic             accept;
    logic [N_OUT-1:0] load;

    // Only the addressed slot gates the producer; its drain frees it in the same cycle.
    assign in_ready = rst_n & (~out_valid[in_sel] | out_ready[in_sel]);
    assign accept   = in_valid & in_ready;
    assign load     = accept ? sel_onehot(in_sel) : '0;

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        stream_slot #(
            .W(W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[g]),
            .data_in  (in_data),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g*W +: W]),
            .cnt      (beat_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule
